// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams and the uart_main transmit handshake shared by uart_tx_arbiter.
// slave = arbiter view, master = producers/UART environment view.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUFFER_WIDTH = 8
);
  logic [NUM_REQ*BUFFER_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_last;
  logic [NUM_REQ-1:0]              req_ready;
  logic [BUFFER_WIDTH-1:0]         tx_data;
  logic                            tx_valid;
  logic                            tx_ready;

  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid
  );

  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of the uart_main transmit port among NUM_REQ byte streams.
// Define UART_TX_ARB_HEADER_EN to prefix every packet with a byte carrying the owner index.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned BUFFER_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout_pulse
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

`ifdef UART_TX_ARB_HEADER_EN
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_STREAM = 2'd1,
    ARB_HEADER = 2'd2
  } arb_state_e;
`else
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_STREAM = 1'b1
  } arb_state_e;
`endif

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [NUM_REQ-1:0] grant_d;
  logic               pulse_d;

  logic                    any_req;
  logic [IDX_W-1:0]        win_idx;
  logic                    owner_valid, owner_last, owner_hs;
  logic [BUFFER_WIDTH-1:0] owner_data;
  logic [BUFFER_WIDTH-1:0] tx_data_c;
  logic                    tx_valid_c;
  logic [NUM_REQ-1:0]      req_ready_c;

  // Index base+off modulo NUM_REQ; off never exceeds NUM_REQ-1, so one subtraction suffices.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // First pending requester searching upward from rr_ptr with wrap.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_req && bus.req_valid[wrap_idx(rr_ptr_q, k)]) begin
        any_req = 1'b1;
        win_idx = wrap_idx(rr_ptr_q, k);
      end
    end
  end

  assign owner_valid = bus.req_valid[grant_idx_q];
  assign owner_last  = bus.req_last[grant_idx_q];
  assign owner_data  = bus.req_data[32'(grant_idx_q)*BUFFER_WIDTH +: BUFFER_WIDTH];
  assign owner_hs    = owner_valid && bus.tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
      stall_cnt_q   <= '0;
      grant         <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      stall_cnt_q   <= stall_cnt_d;
      grant         <= grant_d;
      timeout_pulse <= pulse_d;
    end
  end

  // Next state, arbitration bookkeeping and the zero-latency pass-through to the UART.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    stall_cnt_d = stall_cnt_q;
    grant_d     = grant;
    pulse_d     = 1'b0;
    tx_data_c   = '0;
    tx_valid_c  = 1'b0;
    req_ready_c = '0;

    unique case (state_q)
      ARB_IDLE: begin
        stall_cnt_d = '0;
        if (any_req) begin
          grant_idx_d = win_idx;
          grant_d     = NUM_REQ'(1) << win_idx;
`ifdef UART_TX_ARB_HEADER_EN
          state_d     = ARB_HEADER;
`else
          state_d     = ARB_STREAM;
`endif
        end
      end
`ifdef UART_TX_ARB_HEADER_EN
      ARB_HEADER: begin
        tx_valid_c  = 1'b1;
        tx_data_c   = BUFFER_WIDTH'(grant_idx_q);
        stall_cnt_d = '0;
        if (bus.tx_ready) state_d = ARB_STREAM;
      end
`endif
      ARB_STREAM: begin
        tx_valid_c               = owner_valid;
        tx_data_c                = owner_data;
        req_ready_c[grant_idx_q] = bus.tx_ready;
        if (owner_hs) begin
          stall_cnt_d = '0;
        end else if (!owner_valid && stall_cnt_q != CNT_MAX) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        // Timer only advances while valid is low, so release never cuts a byte in half.
        if (stall_cnt_q == CNT_MAX || (owner_hs && owner_last)) begin
          state_d     = ARB_IDLE;
          grant_d     = '0;
          rr_ptr_d    = wrap_idx(grant_idx_q, 1);
          stall_cnt_d = '0;
          pulse_d     = (stall_cnt_q == CNT_MAX);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.tx_data   = tx_data_c;
  assign bus.tx_valid  = tx_valid_c;
  assign bus.req_ready = req_ready_c;
  assign busy          = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets with hand-ordered expected grants/bytes.
module tb_uart_tx_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned BW = 8;
  localparam int unsigned TO = 8;
  localparam int unsigned IW = $clog2(NR);
`ifdef UART_TX_ARB_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  typedef struct packed {
    logic          hdr;
    logic [IW-1:0] idx;
    logic [BW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] grant;
  logic          busy;
  logic          timeout_pulse;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .BUFFER_WIDTH(BW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .BUFFER_WIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .grant        (grant),
    .busy         (busy),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            last_hs_cyc = 0;
  int            pulses = 0;
  exp_t          exp_q[$];
  logic [BW:0]   rq[NR][$];
  logic [NR-1:0] hs_seen = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, req);
  endtask

  task automatic load(input int r, input logic [BW-1:0] d, input bit last);
    rq[r].push_back({last, d});
  endtask

  task automatic exp_pkt(input int r, input logic [BW-1:0] d);
    if (HDR) exp_q.push_back('{hdr: 1'b1, idx: IW'(r), data: BW'(r)});
    exp_q.push_back('{hdr: 1'b0, idx: IW'(r), data: d});
  endtask

  task automatic exp_byte(input int r, input logic [BW-1:0] d);
    exp_q.push_back('{hdr: 1'b0, idx: IW'(r), data: d});
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input string nm, input int max_cyc);
    int n = 0;
    while (!(exp_q.size() == 0 && all_empty() && !busy) && n < max_cyc) begin
      step();
      n++;
    end
    chk(nm, 64'(n < max_cyc), 64'd1);
  endtask

  // Requester models: present queue head, retire it after an observed handshake.
  initial begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hs_seen[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        hs_seen[i] = 1'b0;
        if (rq[i].size() != 0) begin
          bus.req_valid[i]          = 1'b1;
          bus.req_last[i]           = rq[i][0][BW];
          bus.req_data[i*BW +: BW]  = rq[i][0][BW-1:0];
        end else begin
          bus.req_valid[i]          = 1'b0;
          bus.req_last[i]           = 1'b0;
          bus.req_data[i*BW +: BW]  = '0;
        end
      end
    end
  end

  // Monitor: handshakes pop the scoreboard; ready routing, packet gaps and timeout timing checked.
  initial begin
    bit   in_hdr = 1'b0;
    bit   prev_busy = 1'b0;
    bit   post_last = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      hs_seen = bus.req_valid & bus.req_ready;
      if (!rst_n) begin
        in_hdr = 1'b0; prev_busy = 1'b0; post_last = 1'b0;
        continue;
      end
      if (post_last) begin
        chk("gap_after_last", {60'd0, busy, 3'd0} | 64'(grant), 64'd0);
        post_last = 1'b0;
      end
      if (HDR && busy && !prev_busy) in_hdr = 1'b1;
      prev_busy = busy;
      chk("req_ready_route", 64'(bus.req_ready),
          64'((busy && !in_hdr && bus.tx_ready) ? grant : '0));
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_byte: actual %0h required none", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          chk(e.hdr ? "hdr_byte" : "data_byte",
              {44'd0, bus.tx_data, grant, bus.req_ready},
              {44'd0, e.data, NR'(1) << e.idx, e.hdr ? NR'(0) : NR'(1) << e.idx});
          if (e.hdr) in_hdr = 1'b0;
          else post_last = bus.req_last[e.idx];
        end
        last_hs_cyc = cyc;
      end
      if (timeout_pulse) begin
        pulses++;
        // Counter reaches TO T edges after the handshake; release registers one edge later.
        chk("timeout_latency", 64'(cyc - last_hs_cyc), 64'(TO + 2));
        chk("timeout_grant", 64'(grant), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_ready = 1'b0;
    repeat (3) step();
    chk("rst_grant_busy", {59'd0, busy, grant}, 64'd0);
    chk("rst_tx", {55'd0, bus.tx_valid, bus.tx_data}, 64'd0);
    chk("rst_ready_pulse", {59'd0, timeout_pulse, bus.req_ready}, 64'd0);
    rst_n = 1'b1;

    // One 3-byte packet from requester 1; grant one cycle after valid is seen
    step();
    bus.tx_ready = 1'b1;
    load(1, 8'h11, 1'b0); load(1, 8'h22, 1'b0); load(1, 8'h33, 1'b1);
    exp_pkt(1, 8'h11); exp_byte(1, 8'h22); exp_byte(1, 8'h33);
    step();
    chk("lat_before", {59'd0, busy, grant}, 64'd0);
    step();
    chk("lat_grant", {59'd0, bus.tx_valid, grant}, {59'd0, 1'b1, 4'b0010});
    wait_done("done_t1", 60);

    // Two 1-byte packets per requester; rr_ptr=2 after requester 1
    step();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NR; i++) load(i, 8'(i*16 + p + 1), 1'b1);
    exp_pkt(2, 8'h21); exp_pkt(3, 8'h31); exp_pkt(0, 8'h01); exp_pkt(1, 8'h11);
    exp_pkt(2, 8'h22); exp_pkt(3, 8'h32); exp_pkt(0, 8'h02); exp_pkt(1, 8'h12);
    wait_done("done_t2", 100);

    // tx_ready toggling during a 4-byte packet from requester 0
    step();
    load(0, 8'hA1, 1'b0); load(0, 8'hA2, 1'b0); load(0, 8'hA3, 1'b0); load(0, 8'hA4, 1'b1);
    exp_pkt(0, 8'hA1); exp_byte(0, 8'hA2); exp_byte(0, 8'hA3); exp_byte(0, 8'hA4);
    for (int n = 0; n < 40 && !(exp_q.size() == 0 && !busy); n++) begin
      step();
      bus.tx_ready = ~bus.tx_ready;
    end
    bus.tx_ready = 1'b1;
    wait_done("done_t3", 20);

    // Requester 2 stalls mid-packet; forced release hands over to requester 3
    step();
    load(2, 8'h5A, 1'b0);
    load(3, 8'h77, 1'b1);
    exp_pkt(2, 8'h5A); exp_pkt(3, 8'h77);
    wait_done("done_t4", 80);
    chk("pulse_count", 64'(pulses), 64'd1);

    // Reset while requester 1 is granted and stalled by the UART
    step();
    bus.tx_ready = 1'b0;
    load(1, 8'hC1, 1'b0); load(1, 8'hC2, 1'b1);
    repeat (4) step();
    chk("t5_granted", {59'd0, busy, grant}, {59'd0, 1'b1, 4'b0010});
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_drop", {58'd0, bus.tx_valid, busy, grant}, 64'd0);
    rq[1].delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    bus.tx_ready = 1'b1;
    load(3, 8'hE3, 1'b1);
    load(0, 8'hE0, 1'b1);
    exp_pkt(0, 8'hE0); exp_pkt(3, 8'hE3);
    wait_done("done_t5", 60);

    // Requester 3 alone: header 0x03 (when compiled in) then 0xAB
    step();
    load(3, 8'hAB, 1'b1);
    exp_pkt(3, 8'hAB);
    wait_done("done_t6", 40);

    repeat (3) step();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("pulse_total", 64'(pulses), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
